aurora_flow_nfc_tx: RTL and testbench

- Native-flow-control (NFC) transmitter for the Aurora RX path, in the user_clk domain.
- The RX data path has no backpressure towards the link, so this block watches the RX FIFO fill flags and sends XOFF/XON NFC requests to the Aurora core's NFC AXI-Stream slave. This throttles the link partner before the FIFO overflows.
- It also counts lost beats and pause time for host readout.

---
 rtl/aurora_flow_nfc_pkg.sv | 23 ++
 rtl/aurora_flow_sat_counter.sv | 23 ++
 rtl/aurora_flow_nfc_tx.sv | 175 +++++++++++++++++
 tb/tb_aurora_flow_nfc_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_flow_nfc_pkg.sv
// Shared types and defaults for the Aurora native-flow-control transmitter.
package aurora_flow_nfc_pkg;

    // Width of the NFC AXI-Stream request word
    localparam int NFC_DATA_W = 16;

    // Default request codes: pause / resume the link partner
    localparam logic [NFC_DATA_W-1:0] DEF_XOFF_CODE = 16'h0100;
    localparam logic [NFC_DATA_W-1:0] DEF_XON_CODE  = 16'h0000;

    // Default width of the statistics counters
    localparam int DEF_CNT_W = 32;

    // Flow-control state machine
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SEND_XOFF,
        PAUSED,
        SEND_XON
    } nfc_state_t;

endpackage

// File: rtl/aurora_flow_sat_counter.sv
// Saturating event counter with a dominant synchronous clear.
module aurora_flow_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Count events, stick at all-ones, clear wins over a coincident increment
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/aurora_flow_nfc_tx.sv
// Aurora NFC transmitter: watches the RX FIFO fill flags and throttles the
// link partner with XOFF/XON requests, and keeps drop/pause statistics.
module aurora_flow_nfc_tx
    import aurora_flow_nfc_pkg::*;
#(
    parameter int unsigned             RELEASE_DELAY    = 16,
    parameter int unsigned             REFRESH_INTERVAL = 4096,
    parameter logic [NFC_DATA_W-1:0]   XOFF_CODE        = DEF_XOFF_CODE,
    parameter logic [NFC_DATA_W-1:0]   XON_CODE         = DEF_XON_CODE,
    parameter int                      CNT_W            = DEF_CNT_W
) (
    input  logic                  user_clk,
    input  logic                  reset_u,
    input  logic                  channel_up_u,
    input  logic                  fifo_rx_prog_full_u,
    input  logic                  fifo_rx_almost_full_u,
    input  logic                  m_axi_rx_tvalid_u,
    input  logic                  fifo_rx_tready_u,
    output logic                  s_axi_nfc_tvalid_u,
    output logic [NFC_DATA_W-1:0] s_axi_nfc_tdata_u,
    input  logic                  s_axi_nfc_tready_u,
    input  logic                  clear_stats_u,
    output logic                  nfc_paused_u,
    output logic [CNT_W-1:0]      xoff_count_u,
    output logic [CNT_W-1:0]      pause_cycles_u,
    output logic [CNT_W-1:0]      rx_drop_count_u,
    output logic                  rx_overflow_u
);

    localparam logic [15:0] REL_LIM  = 16'(RELEASE_DELAY);
    localparam logic [31:0] REF_LOAD = 32'(REFRESH_INTERVAL);
    localparam bit          REF_EN   = (REFRESH_INTERVAL != 0);

    nfc_state_t            state, state_nxt;
    logic [15:0]           rel_cnt, rel_cnt_nxt;
    logic [31:0]           ref_cnt, ref_cnt_nxt;
    logic                  tvalid_nxt;
    logic [NFC_DATA_W-1:0] tdata_nxt;
    logic                  paused_nxt;
    logic                  xoff_hs;
    logic                  flags_hi;
    logic                  in_pause;
    logic                  rx_drop;

    assign flags_hi = fifo_rx_prog_full_u || fifo_rx_almost_full_u;
    assign in_pause = (state == PAUSED) || (state == SEND_XON);
    assign rx_drop  = m_axi_rx_tvalid_u && !fifo_rx_tready_u;

    // Next-state, timer and registered-output decode
    always_comb begin
        state_nxt   = state;
        rel_cnt_nxt = rel_cnt;
        ref_cnt_nxt = ref_cnt;
        xoff_hs     = 1'b0;

        if (!channel_up_u) begin
            // Link down: abandon any request in flight and start over
            state_nxt   = IDLE;
            rel_cnt_nxt = '0;
            ref_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = RUN;
                end
                RUN: begin
                    if (flags_hi) begin
                        state_nxt = SEND_XOFF;
                    end
                end
                SEND_XOFF: begin
                    if (s_axi_nfc_tvalid_u && s_axi_nfc_tready_u) begin
                        xoff_hs     = 1'b1;
                        state_nxt   = PAUSED;
                        ref_cnt_nxt = REF_LOAD;
                        rel_cnt_nxt = '0;
                    end
                end
                PAUSED: begin
                    // Release is tested first so it wins over a same-cycle refresh
                    if (rel_cnt == REL_LIM) begin
                        state_nxt   = SEND_XON;
                        rel_cnt_nxt = '0;
                    end else begin
                        rel_cnt_nxt = flags_hi ? 16'd0 : rel_cnt + 16'd1;
                        if (REF_EN) begin
                            if (ref_cnt <= 32'd1) begin
                                state_nxt   = SEND_XOFF;
                                ref_cnt_nxt = '0;
                            end else begin
                                ref_cnt_nxt = ref_cnt - 32'd1;
                            end
                        end
                    end
                end
                SEND_XON: begin
                    // Once offered, XON is never withdrawn even if flags reassert
                    if (s_axi_nfc_tvalid_u && s_axi_nfc_tready_u) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        tvalid_nxt = (state_nxt == SEND_XOFF) || (state_nxt == SEND_XON);

        // Hold the code while no request is pending so tdata only moves on a new request
        tdata_nxt = s_axi_nfc_tdata_u;
        if (state_nxt == SEND_XOFF) begin
            tdata_nxt = XOFF_CODE;
        end else if (state_nxt == SEND_XON) begin
            tdata_nxt = XON_CODE;
        end

        // A refresh XOFF keeps the partner held off, so paused stays asserted through it
        paused_nxt = (state_nxt == PAUSED) || (state_nxt == SEND_XON) ||
                     ((state_nxt == SEND_XOFF) && nfc_paused_u);
    end

    // State, timers and NFC outputs register
    always_ff @(posedge user_clk) begin
        if (reset_u) begin
            state              <= IDLE;
            rel_cnt            <= '0;
            ref_cnt            <= '0;
            s_axi_nfc_tvalid_u <= 1'b0;
            s_axi_nfc_tdata_u  <= XON_CODE;
            nfc_paused_u       <= 1'b0;
        end else begin
            state              <= state_nxt;
            rel_cnt            <= rel_cnt_nxt;
            ref_cnt            <= ref_cnt_nxt;
            s_axi_nfc_tvalid_u <= tvalid_nxt;
            s_axi_nfc_tdata_u  <= tdata_nxt;
            nfc_paused_u       <= paused_nxt;
        end
    end

    // Sticky overflow flag, set by the first dropped beat
    always_ff @(posedge user_clk) begin
        if (reset_u || clear_stats_u) begin
            rx_overflow_u <= 1'b0;
        end else if (rx_drop) begin
            rx_overflow_u <= 1'b1;
        end
    end

    aurora_flow_sat_counter #(.W(CNT_W)) u_xoff_cnt (
        .clk   (user_clk),
        .rst   (reset_u),
        .clr   (clear_stats_u),
        .inc   (xoff_hs),
        .count (xoff_count_u)
    );

    aurora_flow_sat_counter #(.W(CNT_W)) u_pause_cnt (
        .clk   (user_clk),
        .rst   (reset_u),
        .clr   (clear_stats_u),
        .inc   (in_pause),
        .count (pause_cycles_u)
    );

    aurora_flow_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (user_clk),
        .rst   (reset_u),
        .clr   (clear_stats_u),
        .inc   (rx_drop),
        .count (rx_drop_count_u)
    );

endmodule

// File: tb/tb_aurora_flow_nfc_tx.sv
// Directed bench for aurora_flow_nfc_tx. DUT A uses default parameters;
// DUT B uses REFRESH_INTERVAL=8 and CNT_W=4 for refresh and saturation.
module tb_aurora_flow_nfc_tx;

    localparam logic        H    = 1'b1;
    localparam logic        L    = 1'b0;
    localparam logic [15:0] XOFF = 16'h0100;
    localparam logic [15:0] XON  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, chup_a, chup_b, pf, af, rxv, rxr, trdy, clr;
    logic        tv_a, pa_a, ov_a, tv_b, pa_b, ov_b;
    logic [15:0] td_a, td_b;
    logic [31:0] xc_a, pc_a, dc_a;
    logic [3:0]  xc_b, pc_b, dc_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          n;
        logic        chup;
        logic        pf;
        logic        af;
        logic        trdy;
        logic        etv;
        logic [15:0] etd;
        logic        epa;
        int          exc;
        int          epc;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    aurora_flow_nfc_tx dut_a (
        .user_clk              (clk),
        .reset_u               (rst),
        .channel_up_u          (chup_a),
        .fifo_rx_prog_full_u   (pf),
        .fifo_rx_almost_full_u (af),
        .m_axi_rx_tvalid_u     (rxv),
        .fifo_rx_tready_u      (rxr),
        .s_axi_nfc_tvalid_u    (tv_a),
        .s_axi_nfc_tdata_u     (td_a),
        .s_axi_nfc_tready_u    (trdy),
        .clear_stats_u         (clr),
        .nfc_paused_u          (pa_a),
        .xoff_count_u          (xc_a),
        .pause_cycles_u        (pc_a),
        .rx_drop_count_u       (dc_a),
        .rx_overflow_u         (ov_a)
    );

    aurora_flow_nfc_tx #(.REFRESH_INTERVAL(8), .CNT_W(4)) dut_b (
        .user_clk              (clk),
        .reset_u               (rst),
        .channel_up_u          (chup_b),
        .fifo_rx_prog_full_u   (pf),
        .fifo_rx_almost_full_u (af),
        .m_axi_rx_tvalid_u     (rxv),
        .fifo_rx_tready_u      (rxr),
        .s_axi_nfc_tvalid_u    (tv_b),
        .s_axi_nfc_tdata_u     (td_b),
        .s_axi_nfc_tready_u    (trdy),
        .clear_stats_u         (clr),
        .nfc_paused_u          (pa_b),
        .xoff_count_u          (xc_b),
        .pause_cycles_u        (pc_b),
        .rx_drop_count_u       (dc_b),
        .rx_overflow_u         (ov_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic c, input logic p, input logic a, input logic r,
                       input logic etv, input logic [15:0] etd, input logic epa,
                       input int exc, input int epc);
        vec_t v;
        v.n = n; v.chup = c; v.pf = p; v.af = a; v.trdy = r;
        v.etv = etv; v.etd = etd; v.epa = epa; v.exc = exc; v.epc = epc;
        vq.push_back(v);
    endtask

    initial begin
        logic seen;

        rst = H; chup_a = L; chup_b = L; pf = L; af = L;
        rxv = L; rxr = H; trdy = H; clr = L;

        // Table: {cycles, chup, prog_full, almost_full, tready, exp tvalid, exp tdata, exp paused, exp xoff_count, exp pause_cycles}
        // XOFF on prog_full, pause, release 17 edges after flags drop
        add(1,  H, H, L, H, H, XOFF, L, -1, -1);
        add(1,  H, H, L, H, L, XOFF, H,  1,  0);
        add(8,  H, H, L, H, L, XOFF, H, -1,  8);
        add(16, H, L, L, H, L, XOFF, H, -1, 24);
        add(1,  H, L, L, H, H, XON,  H, -1, 25);
        add(1,  H, L, L, H, L, XON,  L,  1, 26);
        // XOFF held under tready low for 5 cycles
        add(1,  H, H, L, L, H, XOFF, L, -1, -1);
        add(1,  H, H, L, L, H, XOFF, L, -1, -1);
        add(1,  H, H, L, L, H, XOFF, L, -1, -1);
        add(1,  H, H, L, L, H, XOFF, L, -1, -1);
        add(1,  H, H, L, L, H, XOFF, L, -1, -1);
        add(1,  H, H, L, L, H, XOFF, L,  1, 26);
        add(1,  H, H, L, H, L, XOFF, H,  2, 26);
        // Release window restarted by almost_full blip
        add(10, H, L, L, H, L, XOFF, H, -1, 36);
        add(1,  H, L, H, H, L, XOFF, H, -1, 37);
        add(16, H, L, L, H, L, XOFF, H, -1, 53);
        add(1,  H, L, L, L, H, XON,  H, -1, 54);
        // Flags reassert during XON: request stays, then RUN re-issues XOFF
        add(1,  H, H, L, L, H, XON,  H, -1, 55);
        add(1,  H, H, L, H, L, XON,  L, -1, 56);
        add(1,  H, H, L, H, H, XOFF, L, -1, -1);
        add(1,  H, H, L, H, L, XOFF, H,  3, 56);
        // Channel drop in SEND_XON with tready low
        add(16, H, L, L, L, L, XOFF, H, -1, 72);
        add(1,  H, L, L, L, H, XON,  H, -1, 73);
        add(1,  H, L, L, L, H, XON,  H, -1, 74);
        add(1,  L, L, L, L, L, XON,  L, -1, 75);
        add(3,  L, H, L, H, L, XON,  L,  3, 75);
        add(1,  H, L, L, H, L, XON,  L, -1, -1);
        add(1,  H, H, L, H, H, XOFF, L, -1, -1);
        add(1,  H, H, L, H, L, XOFF, H,  4, -1);

        // Reset values
        tick(); tick();
        chk("rst_tvalid",  32'(tv_a), 32'd0);
        chk("rst_tdata",   32'(td_a), 32'(XON));
        chk("rst_paused",  32'(pa_a), 32'd0);
        chk("rst_xoff",    xc_a, 32'd0);
        chk("rst_pause",   pc_a, 32'd0);
        chk("rst_drop",    dc_a, 32'd0);
        chk("rst_ovf",     32'(ov_a), 32'd0);
        chk("rst_tvalid_b", 32'(tv_b), 32'd0);

        // Channel up, flags quiet for 100 cycles
        rst = L; chup_a = H;
        seen = L;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tv_a || pa_a) seen = H;
        end
        chk("quiet_no_request", 32'(seen), 32'd0);
        chk("quiet_xoff", xc_a, 32'd0);
        chk("quiet_pause", pc_a, 32'd0);
        chk("quiet_drop", dc_a, 32'd0);

        // Table-driven flow-control sequences on DUT A
        for (int i = 0; i < vq.size(); i++) begin
            chup_a = vq[i].chup; pf = vq[i].pf; af = vq[i].af; trdy = vq[i].trdy;
            repeat (vq[i].n) tick();
            chk($sformatf("vec%0d_tvalid", i), 32'(tv_a), 32'(vq[i].etv));
            if (vq[i].etv) chk($sformatf("vec%0d_tdata", i), 32'(td_a), 32'(vq[i].etd));
            chk($sformatf("vec%0d_paused", i), 32'(pa_a), 32'(vq[i].epa));
            if (vq[i].exc >= 0) chk($sformatf("vec%0d_xoff_count", i), xc_a, 32'(vq[i].exc));
            if (vq[i].epc >= 0) chk($sformatf("vec%0d_pause_cycles", i), pc_a, 32'(vq[i].epc));
        end

        // Refresh on DUT B: XOFF re-sent every 9 cycles while prog_full stays high
        chup_a = L; chup_b = H; pf = L; trdy = H;
        tick();
        pf = H;
        tick();
        chk("ref_first_tvalid", 32'(tv_b), 32'd1);
        chk("ref_first_tdata",  32'(td_b), 32'(XOFF));
        tick();
        chk("ref_first_hs_tvalid", 32'(tv_b), 32'd0);
        chk("ref_first_hs_count",  32'(xc_b), 32'd1);
        repeat (7) tick();
        chk("ref_wait_tvalid", 32'(tv_b), 32'd0);
        chk("ref_wait_paused", 32'(pa_b), 32'd1);
        tick();
        chk("ref_resend_tvalid", 32'(tv_b), 32'd1);
        chk("ref_resend_tdata",  32'(td_b), 32'(XOFF));
        repeat (32) tick();
        chk("ref_xoff_count", 32'(xc_b), 32'd5);
        chk("ref_pause_sat",  32'(pc_b), 32'd15);
        chk("ref_a_xoff_kept", xc_a, 32'd4);
        chup_b = L; pf = L;
        tick();

        // Drop statistics
        rxv = H; rxr = L;
        repeat (3) tick();
        chk("drop3_count", dc_a, 32'd3);
        chk("drop3_ovf",   32'(ov_a), 32'd1);
        chk("drop3_count_b", 32'(dc_b), 32'd3);
        rxv = H; rxr = H;
        tick();
        rxv = L; rxr = L;
        tick();
        chk("no_drop_count", dc_a, 32'd3);
        chk("no_drop_ovf",   32'(ov_a), 32'd1);
        clr = H; rxv = H; rxr = L;
        tick();
        chk("clr_drop_count", dc_a, 32'd0);
        chk("clr_ovf",        32'(ov_a), 32'd0);
        chk("clr_xoff",       xc_a, 32'd0);
        chk("clr_pause",      pc_a, 32'd0);
        clr = L; rxv = L;
        tick();
        chk("after_clr_ovf", 32'(ov_a), 32'd0);
        rxv = H; rxr = L;
        repeat (20) tick();
        rxv = L;
        chk("drop20_count", dc_a, 32'd20);
        chk("drop20_sat_b", 32'(dc_b), 32'd15);
        chk("drop20_ovf_b", 32'(ov_b), 32'd1);

        // Reset clears statistics again
        rst = H;
        tick();
        chk("rst2_drop", dc_a, 32'd0);
        chk("rst2_ovf",  32'(ov_a), 32'd0);
        chk("rst2_tvalid", 32'(tv_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
